// File: rtl/mmss_pkg.sv
// Shared types and digit limits for the mm:ss countdown timer.
package mmss_pkg;

  // Default column limits: minutes span 00..99, seconds span 00..59
  localparam int unsigned MIN_TENS_MAX_DEF = 9;
  localparam int unsigned SEC_TENS_MAX_DEF = 5;
  localparam int unsigned UNITS_MAX_DEF    = 9;

  // One BCD digit
  typedef logic [3:0] digit_t;

  // Timer operating states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Limit a preset digit to the largest value its column can hold
  function automatic digit_t clampDigit(input digit_t value, input digit_t maxVal);
    return (value > maxVal) ? maxVal : value;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// Single BCD digit decrementer; chained least-significant first so a borrow
// ripples from seconds units up to minutes tens.
module bcd_down_digit
  import mmss_pkg::*;
(
  input  digit_t i_digit,
  input  logic   i_borrow,
  input  digit_t i_wrapMax,
  output digit_t o_digit,
  output logic   o_borrow
);

  // A borrow takes one off the digit, wrapping a zero digit to the column max
  always_comb begin
    o_digit = i_digit;
    if (i_borrow) begin
      o_digit = (i_digit == 4'd0) ? i_wrapMax : (i_digit - 4'd1);
    end
  end

  assign o_borrow = i_borrow && (i_digit == 4'd0);

endmodule

// File: rtl/mmss_countdown.sv
// Four-digit BCD minutes:seconds countdown timer with load, start, pause,
// abort and a one-cycle expiry pulse.
module mmss_countdown
  import mmss_pkg::*;
#(
  parameter int unsigned MIN_TENS_MAX = MIN_TENS_MAX_DEF,
  parameter int unsigned SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter int unsigned UNITS_MAX    = UNITS_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [3:0] pre_mt,
  input  logic [3:0] pre_mu,
  input  logic [3:0] pre_st,
  input  logic [3:0] pre_su,
  output logic [3:0] mt,
  output logic [3:0] mu,
  output logic [3:0] st,
  output logic [3:0] su,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam digit_t MT_LIMIT    = digit_t'(MIN_TENS_MAX);
  localparam digit_t ST_LIMIT    = digit_t'(SEC_TENS_MAX);
  localparam digit_t UNITS_LIMIT = digit_t'(UNITS_MAX);

  state_t r_state;
  digit_t r_mt, r_mu, r_st, r_su;
  logic   r_running, r_done, r_expired;

  digit_t w_nextMt, w_nextMu, w_nextSt, w_nextSu;
  logic   w_borrowSu, w_borrowSt, w_borrowMu, w_borrowMt;
  digit_t w_loadMt, w_loadMu, w_loadSt, w_loadSu;
  logic   w_countNonZero, w_nextZero;
  logic   w_loadOk, w_pauseOk, w_startOk, w_tickOk;

  // Borrow chain: seconds units always borrows, so the chain yields count-1
  bcd_down_digit u_digitSu (
    .i_digit   (r_su),
    .i_borrow  (1'b1),
    .i_wrapMax (UNITS_LIMIT),
    .o_digit   (w_nextSu),
    .o_borrow  (w_borrowSu)
  );

  bcd_down_digit u_digitSt (
    .i_digit   (r_st),
    .i_borrow  (w_borrowSu),
    .i_wrapMax (ST_LIMIT),
    .o_digit   (w_nextSt),
    .o_borrow  (w_borrowSt)
  );

  bcd_down_digit u_digitMu (
    .i_digit   (r_mu),
    .i_borrow  (w_borrowSt),
    .i_wrapMax (UNITS_LIMIT),
    .o_digit   (w_nextMu),
    .o_borrow  (w_borrowMu)
  );

  bcd_down_digit u_digitMt (
    .i_digit   (r_mt),
    .i_borrow  (w_borrowMu),
    .i_wrapMax (MT_LIMIT),
    .o_digit   (w_nextMt),
    .o_borrow  (w_borrowMt)
  );

  assign w_loadMt = clampDigit(pre_mt, MT_LIMIT);
  assign w_loadMu = clampDigit(pre_mu, UNITS_LIMIT);
  assign w_loadSt = clampDigit(pre_st, ST_LIMIT);
  assign w_loadSu = clampDigit(pre_su, UNITS_LIMIT);

  assign w_countNonZero = (r_mt != 4'd0) || (r_mu != 4'd0) ||
                          (r_st != 4'd0) || (r_su != 4'd0);
  assign w_nextZero     = (w_nextMt == 4'd0) && (w_nextMu == 4'd0) &&
                          (w_nextSt == 4'd0) && (w_nextSu == 4'd0);

  // A command that its current state does not accept is treated as absent,
  // letting the next lower-priority command act in the same cycle.
  assign w_loadOk  = load  && (r_state != RUN);
  assign w_pauseOk = pause && (r_state == RUN);
  assign w_startOk = start && ((r_state == IDLE) || (r_state == PAUSED)) && w_countNonZero;
  // A borrow out of minutes tens would mean wrapping below 00:00; never commit it
  assign w_tickOk  = tick  && (r_state == RUN) && !w_borrowMt;

  // Timer FSM: priority abort > load > pause > start > tick, all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mt      <= 4'd0;
      r_mu      <= 4'd0;
      r_st      <= 4'd0;
      r_su      <= 4'd0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state   <= IDLE;
        r_mt      <= 4'd0;
        r_mu      <= 4'd0;
        r_st      <= 4'd0;
        r_su      <= 4'd0;
        r_running <= 1'b0;
        r_expired <= 1'b0;
      end else if (w_loadOk) begin
        r_state   <= IDLE;
        r_mt      <= w_loadMt;
        r_mu      <= w_loadMu;
        r_st      <= w_loadSt;
        r_su      <= w_loadSu;
        r_running <= 1'b0;
        r_expired <= 1'b0;
      end else if (w_pauseOk) begin
        r_state   <= PAUSED;
        r_running <= 1'b0;
      end else if (w_startOk) begin
        r_state   <= RUN;
        r_running <= 1'b1;
      end else if (w_tickOk) begin
        r_mt <= w_nextMt;
        r_mu <= w_nextMu;
        r_st <= w_nextSt;
        r_su <= w_nextSu;
        if (w_nextZero) begin
          r_state   <= DONE;
          r_running <= 1'b0;
          r_done    <= 1'b1;
          r_expired <= 1'b1;
        end
      end
    end
  end

  assign mt      = r_mt;
  assign mu      = r_mu;
  assign st      = r_st;
  assign su      = r_su;
  assign running = r_running;
  assign done    = r_done;
  assign expired = r_expired;

endmodule
